uart_tx_fifo: RTL
=================

# uart_tx_fifo

Parametrised, synthesizable UART transmitter with an integrated transmit FIFO. It generalises the bench-side serial launcher with configurable data width, parity mode, stop-bit count, baud divider and queue depth. It also adds back-pressure and overflow reporting. It sits between a byte-producing master (DUT model or bus bridge) and a single TXD line, and it is reusable in both the testbench and the RTL.

## Interface
- DATA_BITS, 8: payload bits per frame, 5..8
- PARITY, 0: 0 = none, 1 = even, 2 = odd
- STOP_BITS, 1: stop bits per frame, 1 or 2
- CLKS_PER_BIT, 16: CLK cycles per serial bit, >= 1
- FIFO_DEPTH, 16: queue entries, power of 2, >= 2
- CLK  in  1  single clock; all state updates on posedge
- RESET  in  1  asynchronous, active-high reset
- WR_DATA  in  DATA_BITS  character to enqueue
- WR_EN  in  1  enqueue strobe, sampled on posedge CLK
- FULL  out  1  FIFO holds FIFO_DEPTH entries
- EMPTY  out  1  FIFO holds 0 entries
- LEVEL  out  $clog2(FIFO_DEPTH)+1  current FIFO occupancy
- OVERFLOW  out  1  one-cycle pulse: write attempted while FULL
- BUSY  out  1  a frame is on the line
- DONE  out  1  one-cycle pulse: a frame's last stop bit completed
- TXD  out  1  serial output; idle high

## Operation
- Reset values: TXD=1, BUSY=0, DONE=0, OVERFLOW=0, EMPTY=1, FULL=0, LEVEL=0. The FSM resets to IDLE and the FIFO pointers and baud counter clear.
- Reset mid-frame aborts the frame: TXD returns high asynchronously, queued data is discarded, and DONE does not pulse.
- FIFO write: when WR_EN=1 and FULL=0, WR_DATA is stored and LEVEL increments.
- When WR_EN=1 and FULL=1, data is dropped, OVERFLOW pulses, and LEVEL is unchanged. FULL is the registered value, so a same-cycle pop does not make room.
- A simultaneous write and pop leaves LEVEL unchanged. Pointers wrap modulo FIFO_DEPTH.
- FSM states: IDLE, START, DATA, PARITY, STOP.
  - IDLE: while EMPTY=1, TXD=1 and BUSY=0. When EMPTY=0, pop the head into the shift register, drive TXD=0, set BUSY=1, and go to START.
  - START -> DATA after CLKS_PER_BIT cycles.
  - DATA: send DATA_BITS bits LSB-first, CLKS_PER_BIT cycles each. Then go to PARITY if PARITY != 0, else to STOP.
  - PARITY: even sends XOR of the data bits; odd sends the inverse of that XOR. Lasts one bit time.
  - STOP: TXD=1 for STOP_BITS*CLKS_PER_BIT cycles.
- End of STOP: DONE pulses. If EMPTY=0, pop on the same edge and go directly to START with no idle gap, keeping BUSY=1. Otherwise go to IDLE with BUSY=0.
- Baud counter counts 0..CLKS_PER_BIT-1 and advances the bit on terminal count. CLKS_PER_BIT=1 gives one bit per cycle.
- Frame length in cycles is CLKS_PER_BIT*(1 + DATA_BITS + (PARITY!=0) + STOP_BITS).
- WR_DATA bits above DATA_BITS do not exist. No truncation logic is needed.

## Timing
- TXD, BUSY and DONE are registered outputs with no combinational path from inputs.
- Write accepted at edge E0 into an empty FIFO with the FSM in IDLE: EMPTY=0 after E0. At E1 the FSM pops, and TXD=0 and BUSY=1 from E1.
- Write-to-start latency is therefore 1 cycle.
- Start bit is low for exactly CLKS_PER_BIT cycles. Every bit is exactly CLKS_PER_BIT cycles, with no jitter.
- DONE is high for the single cycle following the last stop-bit cycle. That is the same edge at which the next start bit begins, or at which BUSY falls.
- OVERFLOW is high for the cycle after the offending edge.
- FULL, EMPTY and LEVEL update on the edge of the write or pop.

## Test plan
- Basic frame (CLKS_PER_BIT=4, 8N1): write 0x55 at E0.
  - TXD=0 for E1..E5.
  - Data bits then follow, 4 cycles each: 1,0,1,0,1,0,1,0.
  - TXD=1 for 4 cycles.
  - DONE pulses once, 40 cycles after E1, and BUSY falls on the same edge.
- Parity: DATA_BITS=7, PARITY=1, write 0x07 -> parity bit 1. PARITY=2, write 0x03 -> parity bit 1. Frame length is CLKS_PER_BIT*10.
- Back-to-back (STOP_BITS=2): write 0x00 then 0xFF on consecutive edges.
  - TXD stays high for exactly 2*CLKS_PER_BIT cycles between the frames.
  - BUSY never drops between the frames.
  - DONE pulses twice.
- Overflow (FIFO_DEPTH=4): six writes on consecutive edges starting with an idle FIFO.
  - FULL asserts after the fifth write.
  - The sixth write causes one OVERFLOW pulse.
  - Exactly five frames are transmitted, in order.
  - LEVEL drains 4->0.
- Reset mid-frame: assert RESET during data bit 3 of a 0xA5 frame with 2 entries queued.
  - TXD=1 immediately; LEVEL=0, BUSY=0, and no DONE pulse.
  - After release, a write of 0x3C transmits correctly with 1-cycle latency.
- CLKS_PER_BIT=1 corner: write 0x81 -> bit sequence 0,1,0,0,0,0,0,0,1,1, one cycle per bit.

Source files
------------

// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo
//
// UART transmitter fed by a small transmit queue. A producer pushes characters
// with WR_EN. The serialiser pops them one at a time and sends each as a frame:
// a start bit, the data bits LSB first, an optional parity bit, then one or two
// stop bits. If the queue is not empty when the last stop bit ends, the next
// frame starts immediately with no idle gap on the line.
//
// Ports
//   CLK       single clock, all state changes on its rising edge
//   RESET     asynchronous, active-high; aborts any frame and flushes the queue
//   WR_DATA   character to enqueue
//   WR_EN     enqueue strobe
//   FULL      queue holds FIFO_DEPTH entries
//   EMPTY     queue holds no entries
//   LEVEL     current queue occupancy
//   OVERFLOW  one-cycle pulse after a write was attempted while FULL
//   BUSY      a frame is on the line
//   DONE      one-cycle pulse after the last stop bit of a frame
//   TXD       serial output, idle high

module uart_tx_fifo #(
   parameter int DATA_BITS    = 8,
   parameter int PARITY       = 0,
   parameter int STOP_BITS    = 1,
   parameter int CLKS_PER_BIT = 16,
   parameter int FIFO_DEPTH   = 16
) (
   input  logic                        CLK,
   input  logic                        RESET,
   input  logic [DATA_BITS-1:0]        WR_DATA,
   input  logic                        WR_EN,
   output logic                        FULL,
   output logic                        EMPTY,
   output logic [$clog2(FIFO_DEPTH):0] LEVEL,
   output logic                        OVERFLOW,
   output logic                        BUSY,
   output logic                        DONE,
   output logic                        TXD
);

   localparam int PTR_W = $clog2(FIFO_DEPTH);
   localparam int LVL_W = PTR_W + 1;
   localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;

   localparam logic [PTR_W-1:0] PTR_ONE   = PTR_W'(1);
   localparam logic [LVL_W-1:0] LVL_ONE   = LVL_W'(1);
   localparam logic [LVL_W-1:0] LVL_FULL  = LVL_W'(FIFO_DEPTH);
   localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
   localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
   localparam logic [2:0]       BIT_LAST  = 3'(DATA_BITS - 1);
   localparam logic             STOP_LAST = (STOP_BITS == 2);

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_START,
      ST_DATA,
      ST_PARITY,
      ST_STOP
   } state_t;

   state_t               state;
   logic [DATA_BITS-1:0] mem [FIFO_DEPTH];
   logic [PTR_W-1:0]     wr_ptr;
   logic [PTR_W-1:0]     rd_ptr;
   logic [LVL_W-1:0]     level;
   logic [CNT_W-1:0]     baud_cnt;
   logic [2:0]           bit_cnt;
   logic                 stop_cnt;
   logic [DATA_BITS-1:0] shift_reg;
   logic                 parity_bit;

   logic [DATA_BITS-1:0] head;
   logic                 head_parity;
   logic                 baud_tc;
   logic                 frame_end;
   logic                 push;
   logic                 pop;

   assign FULL  = (level == LVL_FULL);
   assign EMPTY = (level == '0);
   assign LEVEL = level;

   assign head        = mem[rd_ptr];
   assign head_parity = (PARITY == 2) ? ~(^head) : (^head);

   assign baud_tc   = (baud_cnt == CNT_LAST);
   assign frame_end = (state == ST_STOP) && baud_tc && (stop_cnt == STOP_LAST);

   // FULL is the registered occupancy, so a pop on the same edge never makes
   // room for a write. The serialiser pops either from idle or on the final
   // stop-bit cycle, which is what gives back-to-back frames with no gap.
   assign push = WR_EN && !FULL;
   assign pop  = !EMPTY && ((state == ST_IDLE) || frame_end);

   // Queue storage carries no reset; only the pointers and occupancy define
   // which entries are valid.
   always_ff @(posedge CLK) begin
      if (push) begin
         mem[wr_ptr] <= WR_DATA;
      end
   end

   always_ff @(posedge CLK or posedge RESET) begin
      if (RESET) begin
         wr_ptr   <= '0;
         rd_ptr   <= '0;
         level    <= '0;
         OVERFLOW <= 1'b0;
      end else begin
         OVERFLOW <= WR_EN && FULL;
         if (push) begin
            wr_ptr <= wr_ptr + PTR_ONE;
         end
         if (pop) begin
            rd_ptr <= rd_ptr + PTR_ONE;
         end
         case ({push, pop})
            2'b10:   level <= level + LVL_ONE;
            2'b01:   level <= level - LVL_ONE;
            default: level <= level;
         endcase
      end
   end

   // Frame sequencer. The output bit for the next bit period is registered on
   // the same edge the state advances, so TXD changes exactly on bit
   // boundaries. Parity is computed from the head entry as it is popped, so
   // the shifting data register never has to be re-read.
   always_ff @(posedge CLK or posedge RESET) begin
      if (RESET) begin
         state      <= ST_IDLE;
         baud_cnt   <= '0;
         bit_cnt    <= '0;
         stop_cnt   <= 1'b0;
         shift_reg  <= '0;
         parity_bit <= 1'b0;
         TXD        <= 1'b1;
         BUSY       <= 1'b0;
         DONE       <= 1'b0;
      end else begin
         DONE <= 1'b0;
         if (state != ST_IDLE) begin
            baud_cnt <= baud_tc ? '0 : baud_cnt + CNT_ONE;
         end
         case (state)
            ST_IDLE: begin
               if (pop) begin
                  shift_reg  <= head;
                  parity_bit <= head_parity;
                  bit_cnt    <= '0;
                  baud_cnt   <= '0;
                  TXD        <= 1'b0;
                  BUSY       <= 1'b1;
                  state      <= ST_START;
               end else begin
                  TXD  <= 1'b1;
                  BUSY <= 1'b0;
               end
            end
            ST_START: begin
               if (baud_tc) begin
                  TXD   <= shift_reg[0];
                  state <= ST_DATA;
               end
            end
            ST_DATA: begin
               if (baud_tc) begin
                  if (bit_cnt == BIT_LAST) begin
                     if (PARITY != 0) begin
                        TXD   <= parity_bit;
                        state <= ST_PARITY;
                     end else begin
                        TXD      <= 1'b1;
                        stop_cnt <= 1'b0;
                        state    <= ST_STOP;
                     end
                  end else begin
                     TXD       <= shift_reg[1];
                     shift_reg <= shift_reg >> 1;
                     bit_cnt   <= bit_cnt + 3'd1;
                  end
               end
            end
            ST_PARITY: begin
               if (baud_tc) begin
                  TXD      <= 1'b1;
                  stop_cnt <= 1'b0;
                  state    <= ST_STOP;
               end
            end
            ST_STOP: begin
               if (baud_tc) begin
                  if (stop_cnt == STOP_LAST) begin
                     DONE <= 1'b1;
                     if (pop) begin
                        shift_reg  <= head;
                        parity_bit <= head_parity;
                        bit_cnt    <= '0;
                        TXD        <= 1'b0;
                        state      <= ST_START;
                     end else begin
                        TXD   <= 1'b1;
                        BUSY  <= 1'b0;
                        state <= ST_IDLE;
                     end
                  end else begin
                     stop_cnt <= 1'b1;
                  end
               end
            end
            default: begin
               TXD   <= 1'b1;
               BUSY  <= 1'b0;
               state <= ST_IDLE;
            end
         endcase
      end
   end

endmodule
